// File: rtl/mem_rmw_bridge.sv
// Load/store bridge from the processor memory port to a word-wide synchronous RAM.
// Sub-word stores use read-modify-write; loads are lane-aligned and extended.
module mem_rmw_bridge #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    MemOp,
    input  logic [31:0]   addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int unsigned DW = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state, state_nxt;
    logic          we_q;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic [15:0]   wd_q;

    logic          illegal, misaligned;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [DW-1:0] load_ext, merged;

    logic [DW-1:0] rd_nxt, ram_wdata_nxt;
    logic [AW-1:0] ram_addr_nxt;
    logic          done_nxt, err_nxt, busy_nxt, ram_en_nxt, ram_we_nxt;

    // Address bits above the RAM word index are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{1'b0, addr[DW-1:AW+2]};

    // Request classification, evaluated on the live inputs in IDLE.
    always_comb begin
        illegal    = (MemOp == 3'b011) || (MemOp[2:1] == 2'b11) || (we && MemOp[2]);
        misaligned = ((MemOp[1:0] == 2'b01) && addr[0]) ||
                     ((MemOp[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Lane selection, load extension and store merge from the RAM read word.
    always_comb begin
        lane8    = ram_rdata[7:0];
        lane16   = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_ext = ram_rdata;
        merged   = ram_rdata;
        case (off_q)
            2'd1:    lane8 = ram_rdata[15:8];
            2'd2:    lane8 = ram_rdata[23:16];
            2'd3:    lane8 = ram_rdata[31:24];
            default: lane8 = ram_rdata[7:0];
        endcase
        case (op_q[1:0])
            2'b00:   load_ext = op_q[2] ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
            2'b01:   load_ext = op_q[2] ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
            default: load_ext = ram_rdata;
        endcase
        if (op_q[1:0] == 2'b00) begin
            case (off_q)
                2'd0:    merged[7:0]   = wd_q[7:0];
                2'd1:    merged[15:8]  = wd_q[7:0];
                2'd2:    merged[23:16] = wd_q[7:0];
                default: merged[31:24] = wd_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wd_q;
        end else begin
            merged[15:0] = wd_q;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_nxt     = state;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        ram_en_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        rd_nxt        = rd;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        case (state)
            S_IDLE: begin
                if (req) begin
                    ram_addr_nxt = addr[AW+1:2];
                    if (illegal || misaligned) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end else if (we && (MemOp[1:0] == 2'b10)) begin
                        state_nxt     = S_WR;
                        ram_en_nxt    = 1'b1;
                        ram_we_nxt    = 1'b1;
                        ram_wdata_nxt = wd;
                    end else begin
                        state_nxt  = S_RD;
                        ram_en_nxt = 1'b1;
                    end
                end
            end
            S_RD: state_nxt = S_CAP;
            S_CAP: begin
                if (we_q) begin
                    state_nxt     = S_WR;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = 1'b1;
                    ram_wdata_nxt = merged;
                end else begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    rd_nxt    = load_ext;
                end
            end
            S_WR: begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            op_q      <= 3'b000;
            off_q     <= 2'b00;
            wd_q      <= 16'h0;
            rd        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if ((state == S_IDLE) && req) begin
                we_q  <= we;
                op_q  <= MemOp;
                off_q <= addr[1:0];
                wd_q  <= wd[15:0];
            end
            rd        <= rd_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
            ram_en    <= ram_en_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

endmodule
